// File: rtl/fbcpu_pkg.sv
// Shared definitions for the fbcpu RAM port arbiter: default widths,
// requester IDs and the outstanding-read tag.
package fbcpu_pkg;

  localparam int ADDRESS_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF    = 10;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } rd_tag_t;

  // Consecutive-grant counter step: restart at 1 on owner change, stick at 15.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic same_owner);
    if (!same_owner) begin
      return 4'd1;
    end
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection for the RAM port arbiter.
// Tie policy selected by RAM_ARB_ROUND_ROBIN_EN (alternate) vs. fixed m0 priority.
module arb_pick2
  import fbcpu_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_winner,
  input  logic       burst_hit,
  output logic [1:0] gnt,
  output req_id_e    winner
);

  req_id_e other;

  assign other = (last_winner == REQ_CPU) ? REQ_EXT : REQ_CPU;

  always_comb begin
    gnt    = 2'b00;
    winner = last_winner;
    if (req == 2'b01) begin
      winner = REQ_CPU;
    end else if (req == 2'b10) begin
      winner = REQ_EXT;
    end else if (req == 2'b11) begin
      // A requester that used up its burst hands over regardless of tie policy.
      if (burst_hit) begin
        winner = other;
      end else begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        winner = other;
`else
        winner = REQ_CPU;
`endif
      end
    end
    if (req != 2'b00) begin
      gnt = (winner == REQ_CPU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a CPU port (m0) and a loader/debug port (m1) onto one single-port RAM.
// Tie policy is chosen by RAM_ARB_ROUND_ROBIN_EN inside arb_pick2.
module ram_port_arbiter
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int BURST_MAX     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]    m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [DATA_WIDTH-1:0]    m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]    m1_wdata,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [DATA_WIDTH-1:0]    m1_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  req_id_e     last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  rd_tag_t     tag_q, tag_d;

  logic [1:0]  req_vec;
  logic [1:0]  gnt;
  req_id_e     winner;
  logic        burst_hit;

  // Requests are ignored while reset is held.
  assign req_vec   = {m1_req, m0_req} & {2{~rst}};
  assign burst_hit = (cnt_q >= BURST_LIM);

  arb_pick2 u_pick (
    .req        (req_vec),
    .last_winner(last_q),
    .burst_hit  (burst_hit),
    .gnt        (gnt),
    .winner     (winner)
  );

  always_comb begin
    m0_gnt    = gnt[0];
    m1_gnt    = gnt[1];
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt[0]) begin
      ram_addr  = m0_addr;
      ram_we    = m0_we;
      ram_wdata = m0_wdata;
    end else if (gnt[1]) begin
      ram_addr  = m1_addr;
      ram_we    = m1_we;
      ram_wdata = m1_wdata;
    end

    last_d      = last_q;
    cnt_d       = cnt_q;
    tag_d.valid = (gnt != 2'b00) && !ram_we;
    tag_d.owner = winner;
    if (gnt != 2'b00) begin
      cnt_d  = burst_next(cnt_q, winner == last_q);
      last_d = winner;
    end

    // Read return is gated by rst so a reset cycle hides a pending response.
    m0_rvalid = tag_q.valid && (tag_q.owner == REQ_CPU) && !rst;
    m1_rvalid = tag_q.valid && (tag_q.owner == REQ_EXT) && !rst;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_EXT;
      cnt_q  <= 4'd0;
      tag_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6, RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 10, RAM word width.
REQ-003 Parameter BURST_MAX, default 4, max consecutive grants to one requester while the other is waiting; legal range 1..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 m0_req / m1_req  in  1  access request; m0 = CPU core, m1 = loader/debug port.
REQ-007 mN_we  in  1  1 = write, 0 = read; qualified by mN_req.
REQ-008 mN_addr  in  ADDRESS_WIDTH  access address.
REQ-009 mN_wdata  in  DATA_WIDTH  write data.
REQ-010 mN_gnt  out  1  access accepted this cycle.
REQ-011 mN_rvalid  out  1  read data valid, one cycle after a granted read.
REQ-012 mN_rdata  out  DATA_WIDTH  read data.
REQ-013 ram_addr / ram_we / ram_wdata  out  ADDRESS_WIDTH/1/DATA_WIDTH  single-port RAM command.
REQ-014 ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_addr.

Function
REQ-015 At most one mN_gnt SHALL be high per cycle; gnt SHALL be combinational from the current req inputs and registered arbitration state.
REQ-016 In a cycle with a grant, ram_addr/ram_we/ram_wdata SHALL equal the winner's addr/we/wdata; with no grant: ram_we=0, ram_addr=0, ram_wdata=0.
REQ-017 A single request SHALL be granted in the same cycle (0-cycle arbitration latency, 1 access per cycle).
REQ-018 Requesters hold req/we/addr/wdata stable until gnt; dropping req earlier is legal and cancels the request without side effects.
REQ-019 For a granted read, the next cycle SHALL show mN_rvalid=1 and mN_rdata=ram_rdata for the owner only; the other requester's rvalid=0 and rdata=0.
REQ-020 A registered read tag (valid + owner) SHALL track outstanding reads; granted writes SHALL NOT produce rvalid.
REQ-021 A registered burst counter (4 bits) counts consecutive grants to the same requester; it resets to 1 on owner change and saturates at 15.
REQ-022 With both requesting and count >= BURST_MAX for the last winner, the other requester SHALL win.
REQ-023 With both requesting and count < BURST_MAX, the winner SHALL be chosen by the policy of REQ-027/REQ-028.
REQ-024 Idle cycles (no req) SHALL leave last-winner and counter unchanged.

Reset
REQ-025 Under rst: gnt, rvalid, rdata, ram_* outputs = 0; read tag cleared; counter = 0; last-winner = m1 (m0 wins the first tie).
REQ-026 rst asserted the cycle after a granted read SHALL suppress that rvalid; requests during rst SHALL NOT be granted.

Configuration
REQ-027 Macro RAM_ARB_ROUND_ROBIN_EN defined: on ties, the requester that did not win last SHALL win (strict alternation); BURST_MAX still applies but is implied at 1.
REQ-028 Macro undefined: on ties m0 SHALL win, limited only by BURST_MAX.

Structure
REQ-029 Shared package fbcpu_pkg SHALL hold ADDRESS_WIDTH/DATA_WIDTH defaults, the requester-ID encoding (REQ_CPU=0, REQ_EXT=1) and the read-tag struct.
REQ-030 One sub-module, arb_pick2, SHALL implement the 2-way winner selection from req, last-winner and burst-limit flag; the top holds all registers and muxing.

Verification
REQ-031 Reset, then m0 read addr 0x05 alone, RAM[5]=0x2A5 -> m0_gnt same cycle, next cycle m0_rvalid=1, m0_rdata=0x2A5, m1_rvalid=0.
REQ-032 Both requesting continuously, macro undefined, BURST_MAX=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1...
REQ-033 Same with RAM_ARB_ROUND_ROBIN_EN -> m0,m1,m0,m1...; first tie after reset goes to m0.
REQ-034 m1 write addr 0x3F data 0x3FF, then m0 read 0x3F -> ram_we=1 only in write cycle; m0_rdata=0x3FF; no rvalid for the write.
REQ-035 m0 read granted, rst high next cycle -> m0_rvalid=0, all outputs 0, counter 0; after rst, tie goes to m0.
REQ-036 m1_req dropped before grant while m0 bursting -> no m1 access, no RAM write, m0 continues unaffected.
